// File: rtl/seg_scroll_marquee.sv
// Scrolling-text driver for a bank of seven-segment digits: a small message RAM,
// a frame counter with a step prescaler, and a registered per-digit character select.

module seg_scroll_digit #(
    parameter int IDX     = 0,
    parameter int N_DIG   = 5,
    parameter int MSG_MAX = 8,
    parameter int SEG_W   = 8,
    parameter int FW      = 4,
    parameter int LW      = 4,
    parameter int AW      = 3
) (
    input  logic [FW-1:0]                   f,
    input  logic                            dir,
    input  logic [LW-1:0]                   len,
    input  logic [MSG_MAX-1:0][SEG_W-1:0]   mem,
    output logic [SEG_W-1:0]                code
);
    localparam logic [FW-1:0] POS_FWD = FW'(IDX);
    localparam logic [FW-1:0] POS_REV = FW'(N_DIG - 1 - IDX);

    logic [FW-1:0] pos;
    logic [FW-1:0] k;

    // pos is how many frames after the first character this digit starts showing text
    always_comb begin
        code = '0;
        pos  = dir ? POS_REV : POS_FWD;
        k    = f - pos - FW'(1);
        if (f > pos && k < FW'(len))
            code = mem[k[AW-1:0]];
    end
endmodule

module seg_scroll_marquee #(
    parameter int N_DIG   = 5,
    parameter int MSG_MAX = 8,
    parameter int SEG_W   = 8,
    parameter int DIVW    = 24,
    parameter int LW      = $clog2(MSG_MAX + 1),
    parameter int AW      = $clog2(MSG_MAX)
) (
    input  logic                     ck,
    input  logic                     rs,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     hold,
    input  logic                     loop,
    input  logic                     dir,
    input  logic [LW-1:0]            msg_len,
    input  logic [DIVW-1:0]          div,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [SEG_W-1:0]         wr_data,
    output logic [N_DIG*SEG_W-1:0]   seg,
    output logic                     busy,
    output logic                     done,
    output logic                     wrap
);
    localparam int FW = $clog2(MSG_MAX + N_DIG);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                        state_q, state_d;
    logic [FW-1:0]                 f_q, f_d;
    logic [DIVW-1:0]               cnt_q, cnt_d;
    logic [DIVW-1:0]               div_q, div_d;
    logic [LW-1:0]                 len_q, len_d;
    logic                          dir_q, dir_d;
    logic                          loop_q, loop_d;
    logic                          done_q, done_d;
    logic                          wrap_q, wrap_d;
    logic [MSG_MAX-1:0][SEG_W-1:0] mem_q, mem_d;
    logic [N_DIG-1:0][SEG_W-1:0]   seg_q, seg_d;
    logic [LW-1:0]                 len_clamp;
    logic [FW-1:0]                 f_last;

    always_comb begin
        if (msg_len == '0)
            len_clamp = LW'(1);
        else if (msg_len > LW'(MSG_MAX))
            len_clamp = LW'(MSG_MAX);
        else
            len_clamp = msg_len;
    end

    assign f_last = FW'(len_q) + FW'(N_DIG - 1);

    always_comb begin
        mem_d = mem_q;
        if (wr_en && {1'b0, wr_addr} < (AW+1)'(MSG_MAX))
            mem_d[wr_addr] = wr_data;
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        div_d   = div_q;
        dir_d   = dir_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                f_d   = '0;
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = S_RUN;
                    len_d   = len_clamp;
                    div_d   = div;
                    dir_d   = dir;
                    loop_d  = loop;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    f_d     = '0;
                    cnt_d   = '0;
                end else if (!hold) begin
                    if (cnt_q < div_q) begin
                        cnt_d = cnt_q + DIVW'(1);
                    end else begin
                        cnt_d = '0;
                        if (f_q < f_last) begin
                            f_d = f_q + FW'(1);
                        end else begin
                            f_d = '0;
                            // a looping pass re-samples config so new text settings take effect here
                            if (loop_q) begin
                                wrap_d = 1'b1;
                                len_d  = len_clamp;
                                div_d  = div;
                                dir_d  = dir;
                                loop_d = loop;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar i = 0; i < N_DIG; i++) begin : g_dig
        seg_scroll_digit #(
            .IDX(i), .N_DIG(N_DIG), .MSG_MAX(MSG_MAX), .SEG_W(SEG_W),
            .FW(FW), .LW(LW), .AW(AW)
        ) u_dig (
            .f    (f_q),
            .dir  (dir_q),
            .len  (len_q),
            .mem  (mem_q),
            .code (seg_d[i])
        );
    end

    always_ff @(posedge ck) begin
        if (!rs) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            cnt_q   <= '0;
            len_q   <= LW'(1);
            div_q   <= '0;
            dir_q   <= 1'b0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            mem_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            mem_q   <= mem_d;
            seg_q   <= seg_d;
        end
    end

    assign seg  = seg_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_seg_scroll_marquee.sv
// Directed bench for seg_scroll_marquee: frame contents, pass timing, loop/wrap,
// hold, length clamping, stop and reset.

module tb_seg_scroll_marquee;
    logic        ck = 1'b0;
    logic        rs, start, stop, hold, loop, dir, wr_en;
    logic [3:0]  msg_len;
    logic [23:0] div;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [39:0] seg;
    logic        busy, done, wrap;

    int errors = 0;
    int checks = 0;

    logic [7:0] msg [8] = '{8'h5B, 8'h79, 8'h5E, 8'h40, 8'h77, 8'h3D, 8'h73, 8'h71};

    seg_scroll_marquee dut (
        .ck(ck), .rs(rs), .start(start), .stop(stop), .hold(hold), .loop(loop),
        .dir(dir), .msg_len(msg_len), .div(div), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .seg(seg), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rs = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; loop = 1'b0; dir = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = 4'd8; div = '0;
        tick(2);
        chk("rst_seg", seg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        rs = 1'b1;

        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 3'(a); wr_data = msg[a];
            tick(1);
        end
        wr_en = 1'b0;

        // one-shot, dir=0, div=0
        go();
        chk("r1_busy", busy, 1);
        chk("r1_seg0", seg, 0);
        tick(5);
        chk("r1_f4", seg, 40'h00_5B_79_5E_40);
        tick(1);
        chk("r1_f5", seg, 40'h5B_79_5E_40_77);
        tick(6);
        chk("r1_done_early", done, 0);
        chk("r1_busy12", busy, 1);
        tick(1);
        chk("r1_f12", seg, 40'h71_00_00_00_00);
        chk("r1_done", done, 1);
        chk("r1_idle", busy, 0);
        tick(1);
        chk("r1_blank", seg, 0);
        chk("r1_done_clr", done, 0);

        // one-shot, dir=1
        dir = 1'b1;
        go();
        tick(2);
        chk("r2_f1", seg, 40'h5B_00_00_00_00);
        tick(3);
        chk("r2_f4", seg, 40'h40_5E_79_5B_00);
        tick(1);
        chk("r2_f5", seg, 40'h77_40_5E_79_5B);
        tick(7);
        chk("r2_done", done, 1);
        tick(1);

        // hold for 10 cycles while showing frame 6
        dir = 1'b0;
        go();
        tick(6);
        chk("h_f5", seg, 40'h5B_79_5E_40_77);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("h_frozen", seg, 40'h79_5E_40_77_3D);
        end
        hold = 1'b0;
        tick(1);
        chk("h_rel", seg, 40'h79_5E_40_77_3D);
        tick(1);
        chk("h_f7", seg, 40'h5E_40_77_3D_73);
        tick(4);
        chk("h_done_early", done, 0);
        tick(1);
        chk("h_done", done, 1);
        tick(1);

        // msg_len=0 behaves as length 1
        msg_len = 4'd0;
        go();
        tick(2);
        chk("l0_f1", seg, 40'h00_00_00_00_5B);
        tick(1);
        chk("l0_f2", seg, 40'h00_00_00_5B_00);
        tick(2);
        chk("l0_done_early", done, 0);
        tick(1);
        chk("l0_done", done, 1);
        chk("l0_f5", seg, 40'h5B_00_00_00_00);
        tick(1);

        // msg_len=15 clamps to 8
        msg_len = 4'd15;
        go();
        tick(12);
        chk("l15_done_early", done, 0);
        tick(1);
        chk("l15_done", done, 1);
        chk("l15_f12", seg, 40'h71_00_00_00_00);
        tick(1);

        // looping, div=3; div changed mid-pass must not matter until the wrap
        msg_len = 4'd8; div = 24'd3; loop = 1'b1;
        go();
        tick(5);
        chk("lp_f1", seg, 40'h00_00_00_00_5B);
        tick(3);
        chk("lp_f1_dwell", seg, 40'h00_00_00_00_5B);
        tick(1);
        chk("lp_f2", seg, 40'h00_00_00_5B_79);
        div = 24'd0;
        tick(42);
        chk("lp_wrap_early", wrap, 0);
        chk("lp_busy51", busy, 1);
        div = 24'd3;
        tick(1);
        chk("lp_wrap1", wrap, 1);
        chk("lp_busy52", busy, 1);
        chk("lp_done_none", done, 0);
        tick(1);
        chk("lp_wrap_clr", wrap, 0);
        tick(51);
        chk("lp_wrap2", wrap, 1);

        // stop during frame 7
        tick(29);
        chk("st_f7", seg, 40'h5E_40_77_3D_73);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("st_idle", busy, 0);
        chk("st_no_done", done, 0);
        tick(1);
        chk("st_blank", seg, 0);
        chk("st_no_done2", done, 0);
        chk("st_no_wrap", wrap, 0);

        // reset during frame 5 clears memory
        loop = 1'b0; div = 24'd0;
        go();
        tick(5);
        chk("rr_f4", seg, 40'h00_5B_79_5E_40);
        rs = 1'b0;
        tick(1);
        chk("rr_seg", seg, 0);
        chk("rr_busy", busy, 0);
        chk("rr_done", done, 0);
        chk("rr_wrap", wrap, 0);
        rs = 1'b1;
        go();
        tick(6);
        chk("rr_busy_run", busy, 1);
        chk("rr_blank_f5", seg, 0);
        tick(7);
        chk("rr_done", done, 1);
        chk("rr_blank_f12", seg, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
